input_buffer_stream_reader: RTL and testbench

- Read-side sequencer for the accelerator input buffer.
- On a start command it issues a run of sequential reads: it drives rd_en/rd_addr of the buffer and absorbs the buffer's 1-cycle registered read latency.
- Words go out on a valid/ready stream to the compute datapath through a small credit-managed skid FIFO, so downstream backpressure never loses data.

---
 rtl/input_buffer_stream_reader.sv | 182 ++++++++++++++++++
 tb/tb_input_buffer_stream_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_stream_reader.sv
// ---------------------------------------------------------------------------
// input_buffer_stream_reader
//   Read-side sequencer for the accelerator input buffer. A start command
//   launches a run of sequential reads (base, base+1, ... wrapping modulo the
//   address space). Returned words, which arrive one cycle after each read,
//   are captured into a small skid FIFO and presented on a valid/ready
//   stream. Reads are only issued when the FIFO has room for every word
//   already in flight, so downstream backpressure never loses data.
//
// Ports
//   clk, rst_n    : clock (posedge) and asynchronous active-low reset
//   start         : one-cycle run command, honoured only while idle
//   base_addr     : first read address of the run
//   length        : number of words in the run, 0 .. 2^READER_ADDR_WIDTH
//   abort         : flushes the current run; ignored when idle
//   buf_rd_en     : buffer read enable
//   buf_rd_addr   : buffer read address
//   buf_rd_data   : buffer data, valid the cycle after buf_rd_en
//   m_valid/m_ready/m_data/m_last : output stream; m_last marks the final word
//   busy          : high whenever a run (or its done cycle) is in progress
//   done          : one-cycle pulse when a run completes or is aborted
// ---------------------------------------------------------------------------
module input_buffer_stream_reader #(
  parameter int READER_DATA_WIDTH = 16,
  parameter int READER_ADDR_WIDTH = 4,
  parameter int SKID_DEPTH        = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic        [READER_ADDR_WIDTH-1:0] base_addr,
  input  logic        [READER_ADDR_WIDTH:0]   length,
  input  logic                                abort,
  output logic                                buf_rd_en,
  output logic        [READER_ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic signed [READER_DATA_WIDTH-1:0] buf_rd_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic signed [READER_DATA_WIDTH-1:0] m_data,
  output logic                                m_last,
  output logic                                busy,
  output logic                                done
);

  localparam int CNT_W  = READER_ADDR_WIDTH + 1;
  localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int FCNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [FCNT_W:0]  DEPTH_C = (FCNT_W + 1)'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                         state_q;
  logic [READER_ADDR_WIDTH-1:0]   base_q;
  logic [CNT_W-1:0]               len_q;
  logic [CNT_W-1:0]               issued_q;
  logic [CNT_W-1:0]               sent_q;
  logic                           pending_q;
  logic                           busy_q;
  logic                           done_q;

  logic signed [READER_DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q;
  logic [PTR_W-1:0]               rd_ptr_q;
  logic [FCNT_W-1:0]              count_q;

  logic [FCNT_W:0]                occupancy;
  logic                           flush;
  logic                           push;
  logic                           pop;
  logic                           last_hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    // Words held in the FIFO plus the one still on the buffer data bus.
    occupancy   = {1'b0, count_q} + {{FCNT_W{1'b0}}, pending_q};
    buf_rd_en   = (state_q == S_ISSUE) && (issued_q < len_q) && (occupancy < DEPTH_C);
    buf_rd_addr = base_q + issued_q[READER_ADDR_WIDTH-1:0];
    flush       = abort && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    push        = pending_q && !flush;
    m_valid     = (count_q != '0);
    m_data      = mem_q[rd_ptr_q];
    m_last      = m_valid && (sent_q == (len_q - CNT_W'(1)));
    pop         = m_valid && m_ready;
    last_hs     = pop && m_last;
    busy        = busy_q;
    done        = done_q;
  end

  // Control FSM and run counters.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= buf_rd_en && !flush;
      done_q    <= 1'b0;
      if (buf_rd_en) issued_q <= issued_q + CNT_W'(1);
      if (pop)       sent_q   <= sent_q + CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          // abort is deliberately not looked at here: start always wins.
          if (start) begin
            busy_q <= 1'b1;
            if (length != '0) begin
              base_q   <= base_addr;
              len_q    <= length;
              issued_q <= '0;
              sent_q   <= '0;
              state_q  <= S_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (flush) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (buf_rd_en && ((issued_q + CNT_W'(1)) == len_q)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush || last_hs) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Skid FIFO. The read credit check guarantees a push never meets a full
  // FIFO, so no full flag is needed.
  // NOTE: the storage is reset as well so that m_data reads zero out of
  // reset instead of an undefined head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= buf_rd_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + FCNT_W'(1);
        2'b01:   count_q <= count_q - FCNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_input_buffer_stream_reader
//   Drives directed and randomized runs into input_buffer_stream_reader with
//   a registered-read buffer model. Expected read addresses and stream words
//   are derived as queues from (base, length) and the buffer contents; the
//   in-flight read budget is tracked as reads issued minus words accepted.
// ---------------------------------------------------------------------------
module tb_input_buffer_stream_reader;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int NWORD = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW:0]          length = '0;
  logic                 abort = 1'b0;
  logic                 buf_rd_en;
  logic [AW-1:0]        buf_rd_addr;
  logic signed [DW-1:0] buf_rd_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;

  logic signed [DW-1:0] mem [NWORD];

  int n_tests = 0;
  int n_fail  = 0;

  input_buffer_stream_reader #(
    .READER_DATA_WIDTH(DW),
    .READER_ADDR_WIDTH(AW),
    .SKID_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .abort(abort),
    .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Input buffer: one-cycle registered read.
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   buf_rd_en,   0);
    check({tag, "_rd_addr"}, buf_rd_addr, 0);
    check({tag, "_m_valid"}, m_valid,     0);
    check({tag, "_m_data"},  m_data,      0);
    check({tag, "_m_last"},  m_last,      0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_done"},    done,        0);
  endtask

  // One complete run. mode selects the m_ready pattern (0 always high,
  // 1 pattern 1,0,0,1, 2 random). restart_at issues a second start with
  // different arguments in that cycle; abort_with_start raises abort
  // together with the launching start.
  task automatic run(input int base, input int len, input int mode,
                     input int restart_at, input logic abort_with_start);
    logic [AW-1:0]        exp_addr [$];
    logic signed [DW-1:0] exp_data [$];
    int                   issued  = 0;
    int                   popped  = 0;
    int                   done_c  = -1;
    int                   first_v = -1;
    int                   last_rd = -1;
    logic                 stall   = 1'b0;
    logic signed [DW-1:0] held    = '0;

    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'(base + i));
      exp_data.push_back(mem[(base + i) % NWORD]);
    end

    @(negedge clk);
    start     = 1'b1;
    abort     = abort_with_start;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    m_ready   = 1'b0;

    for (int c = 1; c <= 300 && done_c < 0; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (c == restart_at) begin
        start     = 1'b1;
        base_addr = AW'(base + 7);
        length    = (AW + 1)'(len + 3);
      end else begin
        start = 1'b0;
      end
      m_ready = pick_ready(mode, c);
      #1;
      check("busy_in_run", busy, 1);
      if (stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, held);
      end
      if (buf_rd_en) begin
        check("read_credit", (issued - popped) < DEPTH, 1);
        if (issued < len) check("rd_addr", buf_rd_addr, exp_addr[issued]);
        else              check("extra_read", issued, len);
        issued++;
        last_rd = c;
      end
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) begin
        if (popped < len) begin
          check("m_data", m_data, exp_data[popped]);
          check("m_last", m_last, popped == len - 1);
        end else begin
          check("extra_word", popped, len);
        end
        popped++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      if (done) done_c = c;
    end

    check("done_seen", done_c >= 0, 1);
    check("reads_total", issued, len);
    check("words_total", popped, len);
    if (mode == 0) begin
      check("done_cycle", done_c, (len == 0) ? 1 : len + 3);
      if (len > 0) begin
        check("first_valid_cycle", first_v, 3);
        check("last_read_cycle", last_rd, len);
      end else begin
        check("zero_len_no_valid", first_v, -1);
      end
    end

    @(negedge clk);
    m_ready = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset state.
    for (int i = 0; i < NWORD; i++) mem[i] = DW'(100 + i);
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: addresses 5..8, words 105..108, done on cycle 7.
    run(5, 4, 0, 0, 1'b0);

    // Signed random buffer contents for everything that follows.
    for (int i = 0; i < NWORD; i++) mem[i] = DW'($urandom);

    // Backpressure with the 1,0,0,1 pattern.
    run(2, 6, 1, 0, 1'b0);

    // Address wrap and full-length runs.
    run(14, 3, 0, 0, 1'b0);
    run(0, 16, 0, 0, 1'b0);
    run(9, 16, 1, 0, 1'b0);

    // Zero length: done one cycle later, no reads, no words.
    run(7, 0, 0, 0, 1'b0);

    // Second start during an active run is ignored.
    run(10, 5, 0, 2, 1'b0);

    // abort together with start in IDLE: the run proceeds normally.
    run(9, 2, 0, 0, 1'b1);

    // Abort: length 8, m_ready low, abort in cycle 5.
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(0);
    length    = (AW + 1)'(8);
    m_ready   = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check("abort_pre_rd_en", buf_rd_en, c <= 4);
      if (c == 5) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_rd_en", buf_rd_en, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_done", done, 1);
    check("abort_busy", busy, 1);
    @(negedge clk);
    #1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    check("abort_idle_valid", m_valid, 0);

    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      run(int'($urandom_range(NWORD - 1, 0)), int'($urandom_range(NWORD, 1)), 2, 0, 1'b0);
    end

    // Asynchronous reset while draining, then a normal run.
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(3);
    length    = (AW + 1)'(3);
    m_ready   = 1'b0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_valid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #1 rst_n = 1'b1;
    run(3, 2, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
